// File: rtl/bus_uart_pkg.sv
// Shared constants for the bus-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM encoding.
package bus_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLKDIV = 2'd2;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer wrap bit so that full and empty
// can be told apart without a separate count. The head is readable
// combinationally; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; both may move in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU word bus. Holds the register
// decode, registered read data, the bit timer and the transmit FSM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high; pops the FIFO head as soon as one is available
// ST_START | start bit (line low) for one bit period
// ST_DATA  | eight data bits, LSB first, shifted out of shift
// ST_STOP  | stop bit (line high) for one bit period
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        write,
  input  logic        cs,
  output logic        tx
);

  logic [1:0]  reg_sel;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] clkdiv;
  logic [15:0] bit_timer;
  logic        overflow;
  uart_state_t state;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic [31:0] status_word;
  logic        unused_bus;

  assign reg_sel    = address[3:2];
  assign wr_en      = cs && write;
  assign rd_en      = cs && !write;
  assign fifo_push  = wr_en && (reg_sel == REG_TXDATA);
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
  assign unused_bus = ^{address[1:0], data_in[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (data_in[7:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // STATUS word as seen at the edge that samples a read.
  always_comb begin
    status_word            = '0;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_BUSY]  = (state != ST_IDLE);
    status_word[STAT_OVF]   = overflow;
  end

  // Register writes, sticky overflow and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkdiv   <= DIV_RESET;
      overflow <= 1'b0;
      data_out <= '0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          REG_TXDATA: if (fifo_full) overflow <= 1'b1;
          REG_STATUS: if (data_in[STAT_OVF]) overflow <= 1'b0;
          REG_CLKDIV: clkdiv <= (data_in[15:0] == 16'd0) ? 16'd1 : data_in[15:0];
          default: ;
        endcase
      end
      if (rd_en) begin
        case (reg_sel)
          REG_TXDATA: data_out <= status_word;
          REG_STATUS: data_out <= status_word;
          REG_CLKDIV: data_out <= {16'd0, clkdiv};
          default:    data_out <= '0;
        endcase
      end
    end
  end

  // Transmit FSM; the bit timer reloads from the live CLKDIV at every boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      bit_timer <= '0;
      shift     <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shift     <= fifo_head;
            bit_timer <= clkdiv;
            tx        <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_timer == 16'd0) begin
            bit_timer <= clkdiv;
            bit_idx   <= 3'd0;
            tx        <= shift[0];
            state     <= ST_DATA;
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_timer == 16'd0) begin
            bit_timer <= clkdiv;
            shift     <= {1'b0, shift[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              tx <= shift[1];
            end
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_timer == 16'd0) begin
            tx    <= 1'b1;
            state <= ST_IDLE;
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx. A line recorder stores tx after every
// clock edge; a reference model builds the expected line level per cycle
// from the byte list, the bit-period rules and the one-cycle idle gap.
module tb_bus_uart_tx;

  localparam int MAXC  = 16384;
  localparam int NEVER = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        write;
  logic        cs;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_wr_edge = 0;

  logic tx_hist  [MAXC];
  logic exp_hist [MAXC];

  bus_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd103)) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .write    (write),
    .cs       (cs),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  // cyc = number of the most recent rising edge; tx_hist[k] = tx after edge k
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < MAXC) tx_hist[cyc] = tx;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // All bus tasks start right after a falling edge and end at the next one.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; address = a; data_in = d;
    last_wr_edge = cyc + 1;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    cs = 1'b1; write = 1'b0; address = a;
    @(negedge clk);
    cs = 1'b0;
    d = data_out;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Reference line model: each bit lasts (CLKDIV in force when it starts)+1
  // cycles, a CLKDIV written at edge chg applies to bits starting after chg,
  // and one idle-high cycle follows every frame.
  task automatic model_frames(input int s0, input logic [7:0] bytes[$], input int div0,
                              input int chg, input int div1, output int lo, output int hi);
    int e;
    int p;
    logic [9:0] fr;
    e = s0;
    lo = s0 - 1;
    exp_hist[lo] = 1'b1;
    foreach (bytes[f]) begin
      fr = {1'b1, bytes[f], 1'b0};
      for (int b = 0; b < 10; b++) begin
        p = ((e > chg) ? div1 : div0) + 1;
        for (int k = 0; k < p; k++) exp_hist[e + k] = fr[b];
        e += p;
      end
      exp_hist[e] = 1'b1;
      e += 1;
    end
    for (int k = 0; k < 3; k++) exp_hist[e + k] = 1'b1;
    hi = e + 2;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++;
    if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    reset = 1'b0;
    bus_read(4'h4, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h expected 2", d); end
    bus_read(4'h8, d);
    n_checks++;
    if (d !== 32'd103) begin n_fail++; $display("FAIL reset_clkdiv: got %0d expected 103", d); end
    bus_write(4'hC, 32'hFFFF_FFFF);
    @(negedge clk);
    n_checks++;
    if (data_out !== 32'd103) begin n_fail++; $display("FAIL data_out_hold: got %h expected %h", data_out, 32'd103); end
    bus_read(4'hC, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reserved_read: got %h expected 0", d); end
    bus_read(4'h0, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL txdata_read_status: got %h expected 2", d); end
    bus_read(4'h7, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL low_addr_bits_ignored: got %h expected 2", d); end
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL idle_tx: got %b expected 1", tx); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    logic [7:0] q[$];
    int s0, lo, hi, shown;
    bus_write(4'h8, 32'd3);
    bus_read(4'h8, d);
    n_checks++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL clkdiv_readback: got %0d expected 3", d); end
    bus_write(4'h0, 32'hFFFF_FF68);
    s0 = last_wr_edge + 1;
    q = '{8'h68};
    repeat (8) @(negedge clk);
    bus_read(4'h4, d);
    n_checks++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL status_busy: got %h expected 6", d); end
    model_frames(s0, q, 3, NEVER, 3, lo, hi);
    wait_until(hi + 1);
    shown = 0;
    for (int c = lo; c <= hi; c++) begin
      n_checks++;
      if (tx_hist[c] !== exp_hist[c]) begin
        n_fail++;
        if (shown < 4) $display("FAIL single_frame_tx cycle %0d: got %b expected %b", c - lo, tx_hist[c], exp_hist[c]);
        shown++;
      end
    end
    bus_read(4'h4, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL status_after_frame: got %h expected 2", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0] q[$];
    int s0, lo, hi, shown;
    q = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h00, 8'hFF, 8'hFF, 8'h68};
    bus_write(4'h8, 32'd1);
    foreach (q[i]) begin
      bus_write(4'h0, {24'h0, q[i]});
      if (i == 0) s0 = last_wr_edge + 1;
    end
    bus_write(4'h0, 32'h5A);
    bus_read(4'h4, d);
    n_checks++;
    if (d !== 32'hD) begin n_fail++; $display("FAIL overflow_status: got %h expected d", d); end
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, d);
    n_checks++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL overflow_clear: got %h expected 5", d); end
    model_frames(s0, q, 1, NEVER, 1, lo, hi);
    wait_until(hi + 1);
    shown = 0;
    for (int c = lo; c <= hi; c++) begin
      n_checks++;
      if (tx_hist[c] !== exp_hist[c]) begin
        n_fail++;
        if (shown < 4) $display("FAIL b2b_tx cycle %0d: got %b expected %b", c - lo, tx_hist[c], exp_hist[c]);
        shown++;
      end
    end
    bus_read(4'h4, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL status_after_b2b: got %h expected 2", d); end
  endtask

  task automatic test_div_zero();
    logic [31:0] d;
    logic [7:0] q[$];
    int s0, lo, hi, shown;
    bus_write(4'h8, 32'hABCD_0000);
    bus_read(4'h8, d);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL clkdiv_zero: got %0d expected 1", d); end
    q = '{8'($urandom())};
    bus_write(4'h0, {24'h0, q[0]});
    s0 = last_wr_edge + 1;
    model_frames(s0, q, 1, NEVER, 1, lo, hi);
    wait_until(hi + 1);
    shown = 0;
    for (int c = lo; c <= hi; c++) begin
      n_checks++;
      if (tx_hist[c] !== exp_hist[c]) begin
        n_fail++;
        if (shown < 4) $display("FAIL div_zero_tx cycle %0d: got %b expected %b", c - lo, tx_hist[c], exp_hist[c]);
        shown++;
      end
    end
  endtask

  task automatic test_midframe_div();
    logic [7:0] q[$];
    int s0, lo, hi, shown, chg;
    bus_write(4'h8, 32'd7);
    q = '{8'hA5};
    bus_write(4'h0, 32'hA5);
    s0 = last_wr_edge + 1;
    // data bit 2 occupies edges s0+24 .. s0+31 at 8 clocks per bit
    wait_until(s0 + 25);
    bus_write(4'h8, 32'd3);
    chg = last_wr_edge;
    model_frames(s0, q, 7, chg, 3, lo, hi);
    wait_until(hi + 1);
    shown = 0;
    for (int c = lo; c <= hi; c++) begin
      n_checks++;
      if (tx_hist[c] !== exp_hist[c]) begin
        n_fail++;
        if (shown < 4) $display("FAIL midframe_div_tx cycle %0d: got %b expected %b", c - lo, tx_hist[c], exp_hist[c]);
        shown++;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] w;
    logic [7:0] q[$];
    int s0, lo, hi, shown, sel, div, n;
    for (int it = 0; it < 6; it++) begin
      sel = $urandom_range(0, 5);
      div = (sel == 0) ? 1 : sel;
      w = $urandom();
      w[15:0] = 16'(sel);
      bus_write(4'h8, w);
      bus_read(4'h8, d);
      n_checks++;
      if (d !== 32'(div)) begin n_fail++; $display("FAIL rand_clkdiv: got %0d expected %0d", d, div); end
      n = $urandom_range(1, 8);
      q = {};
      for (int i = 0; i < n; i++) begin
        w = $urandom();
        q.push_back(w[7:0]);
        bus_write(4'h0, w);
        if (i == 0) s0 = last_wr_edge + 1;
      end
      model_frames(s0, q, div, NEVER, div, lo, hi);
      wait_until(hi + 1);
      shown = 0;
      for (int c = lo; c <= hi; c++) begin
        n_checks++;
        if (tx_hist[c] !== exp_hist[c]) begin
          n_fail++;
          if (shown < 4) $display("FAIL rand_tx iter %0d cycle %0d: got %b expected %b", it, c - lo, tx_hist[c], exp_hist[c]);
          shown++;
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int s0, lows;
    bus_write(4'h8, 32'd3);
    bus_write(4'h0, 32'hC3);
    s0 = last_wr_edge + 1;
    bus_write(4'h0, 32'h3C);
    bus_write(4'h0, 32'h81);
    // data bit 2 starts at edge s0+12 with 4-clock bits
    wait_until(s0 + 12);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_midframe_tx: got %b expected 1", tx); end
    bus_read(4'h4, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL reset_midframe_status: got %h expected 2", d); end
    lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL no_frames_after_reset: got %0d low cycles expected 0", lows); end
  endtask

  initial begin
    reset   = 1'b1;
    cs      = 1'b0;
    write   = 1'b0;
    address = 4'h0;
    data_in = 32'h0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_overflow();
    test_div_zero();
    test_midframe_div();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
